// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : UART transmitter with configurable data width, parity and stop
//           bits; optional input FIFO when UART_TX_FIFO_EN is defined.
// Revision: 1.0
// ============================================================================
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int CW       = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q,  baud_d;
  logic [CW-1:0]        bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q,   par_d;
  logic                 last_q,  last_d;
  logic                 tx_q,    tx_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic                 load;
  logic [DATA_BITS-1:0] load_data;
  logic                 baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q,  wr_d;
  logic [AW-1:0]        rd_q,  rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 push;
  logic                 pop;

  // A full FIFO refuses the word even if the FSM pops in the same cycle.
  always_comb begin
    s_ready = (cnt_q != FIFO_FULL);
    push    = s_valid && s_ready;
    pop     = (state_q == S_IDLE) && (cnt_q != '0);
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= s_data;
    end
  end

  assign load      = pop;
  assign load_data = mem_q[rd_q];
`else
  assign s_ready   = (state_q == S_IDLE);
  assign load      = s_valid && s_ready;
  assign load_data = s_data;

  // FIFO_DEPTH has no effect in this build.
  if (FIFO_DEPTH < 2) begin : g_fifo_depth_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = load_data;
          par_d   = (PARITY == 1) ? ~^load_data : ^load_data;
        end
      end
      default: begin
        baud_d = baud_tick ? '0 : baud_q + 1'b1;
        if (baud_tick) begin
          case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + 1'b1;
              if (bit_q == DATA_LAST) begin
                bit_d   = '0;
                state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
              bit_d = bit_q + 1'b1;
              if (bit_q == STOP_LAST) begin
                bit_d   = '0;
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered, so the line trails the state by one clock.
  always_comb begin
    busy_d = (state_q != S_IDLE);
    last_d = (state_q == S_STOP);
    done_d = (state_q == S_IDLE) && last_q;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// Three configurations (8N1, 8E1, 7O2) driven with random traffic and compared
// cycle by cycle against a frame-schedule model of the serial line.
module tb_uart_tx_cfg;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BD        = 10;
  localparam int DEPTH     = 4;
`ifdef UART_TX_FIFO_EN
  localparam bit HAS_FIFO = 1'b1;
`else
  localparam bit HAS_FIFO = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       v_in   [3];
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  logic       rdy_o  [3];
  logic       tx_o   [3];
  logic       busy_o [3];
  logic       done_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .reset(reset), .s_valid(v_in[0]), .s_data(d0),
    .s_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]), .tx_done(done_o[0]));

  uart_tx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .reset(reset), .s_valid(v_in[1]), .s_data(d1),
    .s_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]), .tx_done(done_o[1]));

  uart_tx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .reset(reset), .s_valid(v_in[2]), .s_data(d2),
    .s_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]), .tx_done(done_o[2]));

  function automatic int dbits(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int pmode(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int sbits(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + sbits(i)) * BD;
  endfunction

  // Line level of bit slot j of a frame: start, payload LSB first, parity, stop.
  function automatic logic line_bit(input int i, input logic [8:0] w, input int j);
    int         nb;
    int         ones;
    logic [8:0] payload;
    nb = dbits(i);
    if (j == 0) return 1'b0;
    if (j <= nb) return w[j-1];
    if (pmode(i) != 0 && j == nb + 1) begin
      payload = w & ~(9'h1FF << nb);
      ones    = $countones(payload);
      if (pmode(i) == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [8:0] w);
    v_in[i] = v;
    case (i)
      0:       d0 = w[7:0];
      1:       d1 = w[7:0];
      default: d2 = w[6:0];
    endcase
  endtask

  // Entered at a sample point with the DUT idle; c counts clock edges from there.
  // Frame k is accepted at edge p and enters START at edge s; the line shows it
  // from sample s+1 for frame_len clocks, and tx_done at sample s+1+frame_len.
  task automatic run(input int i, input int ncyc, input logic [8:0] first);
    int         p_q [$];
    int         s_q [$];
    logic [8:0] w_q [$];
    int         fl;
    int         c;
    int         st;
    int         pushes;
    int         starts;
    int         p;
    int         s;
    int         end_c;
    bit         pending;
    bit         accept;
    bit         e_rdy;
    logic       e_tx;
    logic       e_busy;
    logic       e_done;
    logic [8:0] cur;
    fl      = frame_len(i);
    c       = 0;
    end_c   = 0;
    pending = 1'b1;
    cur     = first;
    forever begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rdy  = 1'b1;
      pushes = 0;
      starts = 0;
      foreach (s_q[k]) begin
        st = s_q[k] + 1;
        if (c >= st && c < st + fl) begin
          e_tx   = line_bit(i, w_q[k], (c - st) / BD);
          e_busy = 1'b1;
        end
        if (c == st + fl) e_done = 1'b1;
        if (p_q[k] <= c) pushes++;
        if (s_q[k] <= c) starts++;
        if (!HAS_FIFO && c >= s_q[k] && c < s_q[k] + fl) e_rdy = 1'b0;
      end
      if (HAS_FIFO) e_rdy = (pushes - starts) < DEPTH;
      check_eq($sformatf("d%0d_tx@%0d", i, c), 32'(tx_o[i]), 32'(e_tx));
      check_eq($sformatf("d%0d_busy@%0d", i, c), 32'(busy_o[i]), 32'(e_busy));
      check_eq($sformatf("d%0d_done@%0d", i, c), 32'(done_o[i]), 32'(e_done));
      check_eq($sformatf("d%0d_ready@%0d", i, c), 32'(rdy_o[i]), 32'(e_rdy));
      if (c >= ncyc && !pending && c > end_c) break;
      if (!pending && c < ncyc && $urandom_range(9) < 6) begin
        cur     = 9'($urandom);
        pending = 1'b1;
      end
      drive(i, pending, pending ? cur : 9'($urandom));
      accept = pending && e_rdy;
      @(posedge clk);
      #1;
      c++;
      if (accept) begin
        p = c;
        if (!HAS_FIFO) s = p;
        else if (s_q.size() == 0) s = p + 1;
        else s = (p + 1 > s_q[$] + fl + 1) ? p + 1 : s_q[$] + fl + 1;
        p_q.push_back(p);
        s_q.push_back(s);
        w_q.push_back(cur);
        end_c   = s + fl + 2;
        pending = 1'b0;
      end
    end
    drive(i, 1'b0, 9'h000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 9'h000);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("d%0d_rst_tx", i), 32'(tx_o[i]), 32'd1);
      check_eq($sformatf("d%0d_rst_busy", i), 32'(busy_o[i]), 32'd0);
      check_eq($sformatf("d%0d_rst_done", i), 32'(done_o[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    fork
      run(0, 2500, 9'h0A5);
      run(1, 2500, 9'h007);
      run(2, 2500, 9'h055);
    join

    // Abandon a frame during its start bit, then during payload bit 3.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) drive(i, 1'b1, 9'h1FF);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 9'h000);
      repeat ((r == 0) ? 5 : 45) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("d%0d_pre_rst%0d_busy", i, r), 32'(busy_o[i]), 32'd1);
        check_eq($sformatf("d%0d_pre_rst%0d_tx", i, r), 32'(tx_o[i]), (r == 0) ? 32'd0 : 32'd1);
      end
      #3;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("d%0d_rst%0d_tx", i, r), 32'(tx_o[i]), 32'd1);
        check_eq($sformatf("d%0d_rst%0d_busy", i, r), 32'(busy_o[i]), 32'd0);
        check_eq($sformatf("d%0d_rst%0d_done", i, r), 32'(done_o[i]), 32'd0);
        check_eq($sformatf("d%0d_rst%0d_ready", i, r), 32'(rdy_o[i]), 32'd1);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
    end

    fork
      run(0, 400, 9'h03C);
      run(1, 400, 9'h03C);
      run(2, 400, 9'h03C);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
